// File: rtl/audio_stream_router.sv
// audio_stream_router: N-way stereo source selector, click-free fade-out/switch/fade-in (AUDIO_ROUTER_FADE_EN).
// Latency: 1 clk from the active source strobe to l_valid/r_valid; without AUDIO_ROUTER_FADE_EN gain is unity.
// Backpressure: none; pure strobe stream. A stalled active source pauses the fade indefinitely.
module audio_stream_router #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 24,
  parameter int SEL_W       = 2,
  parameter int RAMP_STEP   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              run,
  input  logic [SEL_W-1:0]                  select,
  input  logic [NUM_SOURCES-1:0]            src_l_valid,
  input  logic [NUM_SOURCES-1:0]            src_r_valid,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_l_data,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_r_data,
  output logic                              l_valid,
  output logic                              r_valid,
  output logic [DATA_WIDTH-1:0]             l_data,
  output logic [DATA_WIDTH-1:0]             r_data,
  output logic [SEL_W-1:0]                  active_sel,
  output logic                              switching
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PASS     = 2'd2;
`ifdef AUDIO_ROUTER_FADE_EN
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;
`endif

  logic [1:0]            state;
  logic                  sel_ok;
  logic                  act_l_vld, act_r_vld;
  logic [DATA_WIDTH-1:0] act_l_dat, act_r_dat;
  logic [DATA_WIDTH-1:0] l_next, r_next;

  // Out-of-range select requests are ignored everywhere.
  assign sel_ok = (32'(select) < NUM_SOURCES);

  // Route only the active source's strobes and samples.
  always_comb begin
    act_l_vld = 1'b0;
    act_r_vld = 1'b0;
    act_l_dat = '0;
    act_r_dat = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (32'(active_sel) == k) begin
        act_l_vld = src_l_valid[k];
        act_r_vld = src_r_valid[k];
        act_l_dat = src_l_data[k*DATA_WIDTH +: DATA_WIDTH];
        act_r_dat = src_r_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AUDIO_ROUTER_FADE_EN
  logic [8:0]       gain;
  logic [SEL_W-1:0] pending_sel;
  logic [SEL_W-1:0] next_pending;
  logic [9:0]       gain_sum;
  logic [8:0]       gain_up, gain_dn;

  // (sample * gain) >>> 8; gain 256 is exact passthrough, shift floors toward -inf.
  function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] s, input logic [8:0] g);
    logic signed [DATA_WIDTH+9:0] p;
    p = (DATA_WIDTH+10)'($signed(s)) * (DATA_WIDTH+10)'($signed({1'b0, g}));
    return DATA_WIDTH'(p >>> 8);
  endfunction

  // Saturating gain steps, the last-wins pending select and the scaled samples.
  always_comb begin
    gain_sum     = {1'b0, gain} + 10'(RAMP_STEP);
    gain_up      = (gain_sum >= 10'd256) ? 9'd256 : gain_sum[8:0];
    gain_dn      = ({1'b0, gain} <= 10'(RAMP_STEP)) ? 9'd0 : gain - 9'(RAMP_STEP);
    next_pending = sel_ok ? select : pending_sel;
    l_next       = scale(act_l_dat, gain);
    r_next       = scale(act_r_dat, gain);
  end

  // Fade FSM: gain only moves on the active right strobe so a stereo pair shares one gain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      gain        <= 9'd0;
      pending_sel <= '0;
      active_sel  <= '0;
      switching   <= 1'b0;
    end else if (!run) begin
      state     <= ST_IDLE;
      gain      <= 9'd0;
      switching <= 1'b0;
    end else begin
      switching <= (state == ST_FADE_IN) || (state == ST_FADE_OUT);
      case (state)
        ST_IDLE: begin
          active_sel <= sel_ok ? select : '0;
          gain       <= 9'd0;
          state      <= ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (sel_ok && select != active_sel) begin
            pending_sel <= select;
            state       <= ST_FADE_OUT;
          end else if (act_r_vld) begin
            gain <= gain_up;
            if (gain_up == 9'd256) state <= ST_PASS;
          end
        end
        ST_PASS: begin
          gain <= 9'd256;
          if (sel_ok && select != active_sel) begin
            pending_sel <= select;
            state       <= ST_FADE_OUT;
          end
        end
        default: begin // ST_FADE_OUT
          pending_sel <= next_pending;
          if (act_r_vld) begin
            gain <= gain_dn;
            if (gain_dn == 9'd0) begin
              active_sel <= next_pending;
              state      <= ST_FADE_IN;
            end
          end
        end
      endcase
    end
  end
`else
  // Unity gain: samples pass through bit-exact.
  always_comb begin
    l_next = act_l_dat;
    r_next = act_r_dat;
  end

  assign switching = 1'b0;

  // Hard switch: a valid select change lands on the next clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      active_sel <= '0;
    end else if (!run) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      active_sel <= sel_ok ? select : '0;
      state      <= ST_PASS;
    end else if (sel_ok && select != active_sel) begin
      active_sel <= select;
    end
  end
`endif

  // Output registers: strobes follow the active source one cycle later; data holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_valid <= 1'b0;
      r_valid <= 1'b0;
      l_data  <= '0;
      r_data  <= '0;
    end else if (!run || state == ST_IDLE) begin
      l_valid <= 1'b0;
      r_valid <= 1'b0;
      l_data  <= '0;
      r_data  <= '0;
    end else begin
      l_valid <= act_l_vld;
      r_valid <= act_r_vld;
      if (act_l_vld) l_data <= l_next;
      if (act_r_vld) r_data <= r_next;
    end
  end

endmodule

// File: tb/tb_audio_stream_router.sv
// Directed bench for audio_stream_router (4 sources, 24-bit, 3-bit select so out-of-range values are reachable).
// Without AUDIO_ROUTER_FADE_EN a vector table checks the hard-switch passthrough; with it, hand sequences check the fades.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_audio_stream_router;
  localparam int NS = 4;
  localparam int DW = 24;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              run;
  logic [SW-1:0]     select;
  logic [NS-1:0]     src_l_valid, src_r_valid;
  logic [NS*DW-1:0]  src_l_data, src_r_data;
  logic              l_valid, r_valid, switching;
  logic [DW-1:0]     l_data, r_data;
  logic [SW-1:0]     active_sel;
  logic [DW-1:0]     l_vals [NS];
  logic [DW-1:0]     r_vals [NS];

  int vec_cnt = 0;
  int err_cnt = 0;

  audio_stream_router #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .SEL_W(SW), .RAMP_STEP(16)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .select(select),
    .src_l_valid(src_l_valid), .src_r_valid(src_r_valid),
    .src_l_data(src_l_data), .src_r_data(src_r_data),
    .l_valid(l_valid), .r_valid(r_valid), .l_data(l_data), .r_data(r_data),
    .active_sel(active_sel), .switching(switching)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      src_l_data[k*DW +: DW] = l_vals[k];
      src_r_data[k*DW +: DW] = r_vals[k];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_l_valid = '0;
    src_r_valid = '0;
    step();
  endtask

  // One stereo pair on every source at once; optionally check both output channels.
  task automatic pair(input bit do_chk, input string nm, input logic [DW-1:0] exp);
    src_l_valid = '1;
    src_r_valid = '1;
    step();
    if (do_chk) begin
      chk({nm, " l_valid"}, 32'(l_valid), 32'd1);
      chk({nm, " l_data"}, 32'(l_data), 32'(exp));
      chk({nm, " r_data"}, 32'(r_data), 32'(exp));
    end
  endtask

  typedef struct {
    logic          run;
    logic [SW-1:0] sel;
    logic [NS-1:0] lm;
    logic [NS-1:0] rm;
    logic [DW-1:0] base;
    logic          e_lv;
    logic          e_rv;
    logic [DW-1:0] e_l;
    logic [DW-1:0] e_r;
    logic [SW-1:0] e_sel;
  } vec_t;

  initial begin
`ifndef AUDIO_ROUTER_FADE_EN
    vec_t vt [13];
`endif
    reset_n = 1'b0;
    run = 1'b0;
    select = '0;
    src_l_valid = '0;
    src_r_valid = '0;
    for (int k = 0; k < NS; k++) begin
      l_vals[k] = '0;
      r_vals[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset l_valid", 32'(l_valid), 32'd0);
    chk("reset r_valid", 32'(r_valid), 32'd0);
    chk("reset l_data", 32'(l_data), 32'd0);
    chk("reset active_sel", 32'(active_sel), 32'd0);
    chk("reset switching", 32'(switching), 32'd0);
    reset_n = 1'b1;

`ifndef AUDIO_ROUTER_FADE_EN
    // src k: left = base + k, right = base + 16 + k
    //          run   sel   lm     rm     base           lv    rv    l             r             sel
    vt[0]  = '{1'b0, 3'd0, 4'h0, 4'h0, 24'h001000, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'd0};
    vt[1]  = '{1'b1, 3'd2, 4'h4, 4'h4, 24'h001000, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'd2};
    vt[2]  = '{1'b1, 3'd2, 4'h4, 4'h4, 24'h002000, 1'b1, 1'b1, 24'h002002, 24'h002012, 3'd2};
    vt[3]  = '{1'b1, 3'd2, 4'h4, 4'h0, 24'h003000, 1'b1, 1'b0, 24'h003002, 24'h002012, 3'd2};
    vt[4]  = '{1'b1, 3'd2, 4'h3, 4'h3, 24'h004000, 1'b0, 1'b0, 24'h003002, 24'h002012, 3'd2};
    vt[5]  = '{1'b1, 3'd5, 4'h4, 4'h4, 24'h005000, 1'b1, 1'b1, 24'h005002, 24'h005012, 3'd2};
    vt[6]  = '{1'b1, 3'd1, 4'h4, 4'h4, 24'h006000, 1'b1, 1'b1, 24'h006002, 24'h006012, 3'd1};
    vt[7]  = '{1'b1, 3'd1, 4'h2, 4'h2, 24'h0FFFF0, 1'b1, 1'b1, 24'h0FFFF1, 24'h100001, 3'd1};
    vt[8]  = '{1'b1, 3'd1, 4'h2, 4'h2, 24'h800000, 1'b1, 1'b1, 24'h800001, 24'h800011, 3'd1};
    vt[9]  = '{1'b0, 3'd1, 4'h2, 4'h2, 24'h000001, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'd1};
    vt[10] = '{1'b0, 3'd1, 4'h2, 4'h2, 24'h000001, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'd1};
    vt[11] = '{1'b1, 3'd3, 4'h8, 4'h8, 24'h000100, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'd3};
    vt[12] = '{1'b1, 3'd3, 4'h8, 4'h0, 24'h007000, 1'b1, 1'b0, 24'h007003, 24'h000000, 3'd3};
    for (int i = 0; i < 13; i++) begin
      run = vt[i].run;
      select = vt[i].sel;
      src_l_valid = vt[i].lm;
      src_r_valid = vt[i].rm;
      for (int k = 0; k < NS; k++) begin
        l_vals[k] = vt[i].base + 24'(k);
        r_vals[k] = vt[i].base + 24'(16 + k);
      end
      step();
      chk($sformatf("v%0d l_valid", i), 32'(l_valid), 32'(vt[i].e_lv));
      chk($sformatf("v%0d r_valid", i), 32'(r_valid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d l_data", i), 32'(l_data), 32'(vt[i].e_l));
      chk($sformatf("v%0d r_data", i), 32'(r_data), 32'(vt[i].e_r));
      chk($sformatf("v%0d active_sel", i), 32'(active_sel), 32'(vt[i].e_sel));
      chk($sformatf("v%0d switching", i), 32'(switching), 32'd0);
    end
    // Reset mid-stream clears everything asynchronously.
    src_l_valid = 4'h8;
    src_r_valid = 4'h8;
    for (int k = 0; k < NS; k++) begin
      l_vals[k] = 24'h009000 + 24'(k);
      r_vals[k] = 24'h009010 + 24'(k);
    end
    step();
    chk("pre-reset l_data", 32'(l_data), 32'h009003);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset l_valid", 32'(l_valid), 32'd0);
    chk("async reset l_data", 32'(l_data), 32'd0);
    chk("async reset r_data", 32'(r_data), 32'd0);
    chk("async reset active_sel", 32'(active_sel), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post-reset idle l_valid", 32'(l_valid), 32'd0);
    step();
    chk("post-reset l_valid", 32'(l_valid), 32'd1);
    chk("post-reset l_data", 32'(l_data), 32'h009003);
    chk("post-reset active_sel", 32'(active_sel), 32'd3);
`else
    l_vals[0] = 24'h050000; r_vals[0] = 24'h050000;
    l_vals[1] = 24'h300000; r_vals[1] = 24'h300000;
    l_vals[2] = 24'h100000; r_vals[2] = 24'h100000;
    l_vals[3] = 24'h200000; r_vals[3] = 24'h200000;
    // Startup on source 2: gain 0,16,...,256 -> outputs 0, 0x010000, ... 0x100000.
    run = 1'b1;
    select = 3'd2;
    idle();
    chk("start active_sel", 32'(active_sel), 32'd2);
    chk("start no strobe", 32'(l_valid), 32'd0);
    idle();
    chk("start switching", 32'(switching), 32'd1);
    for (int i = 0; i <= 16; i++)
      pair(1'b1, $sformatf("ramp%0d", i), 24'(((i < 16) ? i : 16) * 32'h10000));
    chk("ramp done switching", 32'(switching), 32'd0);
    idle();
    chk("latency no strobe", 32'(l_valid), 32'd0);
    // Switch 2 -> 3: 16 pairs out, active_sel flips on the gain-0 edge, 16 pairs in.
    select = 3'd3;
    idle();
    for (int j = 0; j < 16; j++) begin
      pair(1'b1, $sformatf("fout%0d", j), 24'((16 - j) * 32'h10000));
      if (j == 14) chk("fout sel held", 32'(active_sel), 32'd2);
    end
    chk("fout sel flip", 32'(active_sel), 32'd3);
    for (int m = 0; m <= 16; m++)
      pair(1'b1, $sformatf("fin%0d", m), 24'(((m < 16) ? m : 16) * 32'h20000));
    idle();
    chk("fin switching", 32'(switching), 32'd0);
    // Move to source 1, then load it with negative full scale.
    select = 3'd1;
    idle();
    for (int j = 0; j < 16; j++) pair(1'b0, "", '0);
    for (int m = 0; m < 16; m++) pair(1'b0, "", '0);
    pair(1'b1, "src1 unity", 24'h300000);
    l_vals[1] = 24'h800000;
    r_vals[1] = 24'h800000;
    // Reversal 1 -> 3 -> 1 at gain 128.
    select = 3'd3;
    idle();
    for (int j = 0; j < 8; j++) pair(1'b0, "", '0);
    select = 3'd1;
    idle();
    pair(1'b1, "neg gain128", 24'hC00000);
    for (int j = 0; j < 7; j++) pair(1'b0, "", '0);
    chk("reversal active_sel", 32'(active_sel), 32'd1);
    chk("reversal switching", 32'(switching), 32'd1);
    for (int m = 0; m < 16; m++) pair(1'b0, "", '0);
    pair(1'b1, "reversal unity", 24'h800000);
    idle();
    chk("reversal done", 32'(switching), 32'd0);
    // Out-of-range select is ignored.
    select = 3'd5;
    idle();
    idle();
    chk("oor switching", 32'(switching), 32'd0);
    chk("oor active_sel", 32'(active_sel), 32'd1);
    pair(1'b1, "oor data", 24'h800000);
    // run low clears outputs on the next edge.
    run = 1'b0;
    src_l_valid = '1;
    src_r_valid = '1;
    step();
    chk("run low l_valid", 32'(l_valid), 32'd0);
    chk("run low l_data", 32'(l_data), 32'd0);
    // Reset while streaming.
    run = 1'b1;
    select = 3'd1;
    idle();
    pair(1'b0, "", '0);
    pair(1'b0, "", '0);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset l_valid", 32'(l_valid), 32'd0);
    chk("async reset l_data", 32'(l_data), 32'd0);
    chk("async reset r_data", 32'(r_data), 32'd0);
    chk("async reset active_sel", 32'(active_sel), 32'd0);
    chk("async reset switching", 32'(switching), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
